// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - multicycle memory access sequencer (IDLE/REQ/DONE)
// Optional REQ-state timeout with bus error enabled by macro MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        IRWr,
  input  logic        IorD,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wr_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_n;
  logic        mem_req_n, mem_we_n, ir_sel, ir_sel_n, addr_err_n;
  logic [31:0] mem_addr_n, mem_wdata_n, ir_n, mdr_n;
  logic [31:0] req_addr;
  logic        req_active, aligned;

  assign req_addr   = IorD ? alu_out : pc;
  assign req_active = MemRd | MemWr;
  assign aligned    = (req_addr[1:0] == 2'b00);
  assign stall      = (state == REQ) || (state == IDLE && req_active && aligned);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt, to_cnt_n;
  logic       bus_err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_n;
      bus_err <= bus_err_n;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign bus_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      ir_sel    <= 1'b0;
      ir        <= 32'd0;
      mdr       <= 32'd0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      ir_sel    <= ir_sel_n;
      ir        <= ir_n;
      mdr       <= mdr_n;
      addr_err  <= addr_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    ir_sel_n    = ir_sel;
    ir_n        = ir;
    mdr_n       = mdr;
    addr_err_n  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    to_cnt_n    = to_cnt;
    bus_err_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_active) begin
          if (!aligned) begin
            addr_err_n = 1'b1;
          end else begin
            // Write wins when both strobes are high.
            mem_addr_n  = req_addr;
            mem_wdata_n = wr_data;
            mem_we_n    = MemWr;
            ir_sel_n    = IRWr;
            mem_req_n   = 1'b1;
            state_n     = REQ;
`ifdef MEM_TIMEOUT_EN
            to_cnt_n    = 8'd0;
`endif
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!mem_we) begin
            if (ir_sel) ir_n = mem_rdata;
            else        mdr_n = mem_rdata;
          end
          mem_req_n = 1'b0;
          state_n   = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          mem_req_n = 1'b0;
          bus_err_n = 1'b1;
          state_n   = DONE;
        end else begin
          to_cnt_n = to_cnt + 8'd1;
        end
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRd, MemWr, IRWr, IorD;
  logic [31:0] pc, alu_out, wr_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ir, mdr;
  logic        stall, addr_err, bus_err;

  int checks = 0;
  int failures = 0;
  int stall_cycles = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .IRWr(IRWr), .IorD(IorD),
    .pc(pc), .alu_out(alu_out), .wr_data(wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .mdr(mdr),
    .stall(stall), .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Sample stall before the edge, then advance to 2 time units past it.
  task automatic step();
    #1;
    if (stall === 1'b1) stall_cycles++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; MemRd = 0; MemWr = 0; IRWr = 0; IorD = 0;
    pc = 0; alu_out = 0; wr_data = 0; mem_ack = 0; mem_rdata = 0;
    #12;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_mdr", mdr, 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Fetch
    stall_cycles = 0;
    MemRd = 1; IRWr = 1; IorD = 0; pc = 32'h40;
    #1 check("fetch_stall_idle", 32'(stall), 32'd1);
    step();
    MemRd = 0; IRWr = 0;
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h40);
    check("fetch_mem_we", 32'(mem_we), 32'd0);
    mem_ack = 1; mem_rdata = 32'h8C220004;
    step();
    mem_ack = 0;
    check("fetch_ir", ir, 32'h8C220004);
    check("fetch_mdr", mdr, 32'd0);
    check("fetch_req_done", 32'(mem_req), 32'd0);
    #1 check("fetch_stall_done", 32'(stall), 32'd0);
    step();
    check("fetch_stall_cycles", 32'(stall_cycles), 32'd2);

    // Load with 4 REQ cycles
    stall_cycles = 0;
    MemRd = 1; IorD = 1; alu_out = 32'h100; IRWr = 0;
    step();
    MemRd = 0;
    check("load_addr", mem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      step();
      check("load_req_wait", 32'(mem_req), 32'd1);
    end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 0;
    check("load_mdr", mdr, 32'hDEADBEEF);
    check("load_ir_kept", ir, 32'h8C220004);
    step();
    check("load_stall_cycles", 32'(stall_cycles), 32'd5);

    // Stray ack in IDLE
    mem_ack = 1; mem_rdata = 32'h55555555;
    step();
    mem_ack = 0;
    check("stray_ack_mdr", mdr, 32'hDEADBEEF);
    check("stray_ack_ir", ir, 32'h8C220004);
    check("stray_ack_req", 32'(mem_req), 32'd0);

    // Store with both strobes high
    MemWr = 1; MemRd = 1; IorD = 1; alu_out = 32'h200; wr_data = 32'h12345678;
    step();
    MemWr = 0; MemRd = 0; alu_out = 32'h0; wr_data = 32'h0;
    check("store_we", 32'(mem_we), 32'd1);
    check("store_addr", mem_addr, 32'h200);
    check("store_wdata", mem_wdata, 32'h12345678);
    step();
    check("store_wdata_hold", mem_wdata, 32'h12345678);
    check("store_addr_hold", mem_addr, 32'h200);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 0;
    check("store_ir_kept", ir, 32'h8C220004);
    check("store_mdr_kept", mdr, 32'hDEADBEEF);
    check("store_req_done", 32'(mem_req), 32'd0);
    step();

    // Misaligned
    MemRd = 1; IorD = 1; alu_out = 32'h102;
    #1 check("mis_stall", 32'(stall), 32'd0);
    step();
    MemRd = 0;
    check("mis_addr_err", 32'(addr_err), 32'd1);
    check("mis_req", 32'(mem_req), 32'd0);
    step();
    check("mis_addr_err_end", 32'(addr_err), 32'd0);
    check("mis_req_end", 32'(mem_req), 32'd0);

    // Reset in the middle of REQ
    MemRd = 1; IorD = 0; pc = 32'h80; IRWr = 1;
    step();
    MemRd = 0; IRWr = 0;
    check("rreq_req", 32'(mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rreq_req_drop", 32'(mem_req), 32'd0);
    check("rreq_ir", ir, 32'd0);
    check("rreq_mdr", mdr, 32'd0);
    #1 rst = 1'b0;
    mem_ack = 1; mem_rdata = 32'h11111111;
    step();
    mem_ack = 0;
    check("rreq_ack_ir", ir, 32'd0);
    check("rreq_ack_mdr", mdr, 32'd0);
    check("rreq_ack_req", 32'(mem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Timeout after 4 REQ cycles
    MemRd = 1; IorD = 1; alu_out = 32'h300; IRWr = 0;
    step();
    MemRd = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_req_wait", 32'(mem_req), 32'd1);
      check("to_no_bus_err", 32'(bus_err), 32'd0);
    end
    step();
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_req_drop", 32'(mem_req), 32'd0);
    #1 check("to_stall_done", 32'(stall), 32'd0);
    check("to_mdr_kept", mdr, 32'd0);
    step();
    check("to_bus_err_end", 32'(bus_err), 32'd0);
`else
    // No timeout: REQ waits indefinitely
    MemRd = 1; IorD = 1; alu_out = 32'h300; IRWr = 0;
    step();
    MemRd = 0;
    for (int i = 0; i < 300; i++) step();
    check("wait_req_held", 32'(mem_req), 32'd1);
    check("wait_bus_err", 32'(bus_err), 32'd0);
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    step();
    mem_ack = 0;
    check("wait_mdr", mdr, 32'h0BADF00D);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
